exe_muldiv: RTL and testbench



---
 rtl/exe_muldiv_pkg.sv | 38 +++
 rtl/exe_muldiv_negate.sv | 19 +
 rtl/exe_muldiv.sv | 176 +++++++++++++++++
 tb/tb_exe_muldiv.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/exe_muldiv_pkg.sv
// Shared constants and helpers for the iterative multiply/divide unit.
package exe_muldiv_pkg;

    localparam int WORD = 32;

    localparam logic [2:0] MD_OP_MUL   = 3'd0;
    localparam logic [2:0] MD_OP_MULH  = 3'd1;
    localparam logic [2:0] MD_OP_MULHU = 3'd2;
    localparam logic [2:0] MD_OP_DIV   = 3'd3;
    localparam logic [2:0] MD_OP_MOD   = 3'd4;
    localparam logic [2:0] MD_OP_DIVU  = 3'd5;
    localparam logic [2:0] MD_OP_MODU  = 3'd6;
    localparam logic [2:0] MD_OP_RSVD  = 3'd7;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

    function automatic logic md_op_is_div(input logic [2:0] op);
        return (op == MD_OP_DIV) || (op == MD_OP_MOD) || (op == MD_OP_DIVU) || (op == MD_OP_MODU);
    endfunction

    function automatic logic md_op_is_mod(input logic [2:0] op);
        return (op == MD_OP_MOD) || (op == MD_OP_MODU);
    endfunction

    function automatic logic md_op_is_signed(input logic [2:0] op);
        return (op == MD_OP_MUL) || (op == MD_OP_MULH) || (op == MD_OP_DIV) || (op == MD_OP_MOD);
    endfunction

    function automatic logic md_op_is_high(input logic [2:0] op);
        return (op == MD_OP_MULH) || (op == MD_OP_MULHU);
    endfunction

endpackage

// File: rtl/exe_muldiv_negate.sv
// Conditional two's-complement negation of a P-bit value.
module md_negate #(
    parameter int P = 32
) (
    input  logic         neg,
    input  logic [P-1:0] a,
    output logic [P-1:0] y
);

    // Negate when requested, otherwise pass through.
    always_comb begin
        if (neg) begin
            y = ~a + P'(1);
        end else begin
            y = a;
        end
    end

endmodule

// File: rtl/exe_muldiv.sv
// Iterative radix-2 multiply/divide unit: sign-magnitude operands, one
// shift-add or restoring shift-subtract step per cycle, sign fix-up at the end.
module exe_muldiv
    import exe_muldiv_pkg::*;
#(
    parameter int WIDTH = WORD,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src0,
    input  logic [WIDTH-1:0] src1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    md_state_e          state_r;
    logic [2:0]         op_r;
    logic               sign_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   opb_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [WIDTH-1:0]   rem_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic               busy_r;
    logic [WIDTH-1:0]   result_r;

    logic               is_div_s;
    logic               neg0_s;
    logic               neg1_s;
    logic               div_zero_s;
    logic               accept_s;
    logic [WIDTH-1:0]   mag0_s;
    logic [WIDTH-1:0]   mag1_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_shift_s;
    logic [WIDTH:0]     div_diff_s;
    logic [2*WIDTH-1:0] fix_in_s;
    logic [2*WIDTH-1:0] fix_out_s;
    logic [WIDTH-1:0]   result_fix_s;

    assign is_div_s   = md_op_is_div(op);
    assign neg0_s     = md_op_is_signed(op) & src0[WIDTH-1];
    assign neg1_s     = md_op_is_signed(op) & src1[WIDTH-1];
    assign div_zero_s = is_div_s & (src1 == {WIDTH{1'b0}});
    assign accept_s   = in_valid & in_ready_r & ~flush;

    md_negate #(.P(WIDTH)) u_mag0 (.neg(neg0_s), .a(src0), .y(mag0_s));
    md_negate #(.P(WIDTH)) u_mag1 (.neg(neg1_s), .a(src1), .y(mag1_s));

    // Single-step datapath candidates for the multiply and divide iterations.
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (acc_r[0] ? {1'b0, opb_r} : {(WIDTH+1){1'b0}});
        div_shift_s = {rem_r, acc_r[WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, opb_r};
    end

    // Select what the sign fix-up operates on: product, quotient or remainder.
    always_comb begin
        if (md_op_is_mod(op_r)) begin
            fix_in_s = {{WIDTH{1'b0}}, rem_r};
        end else if (md_op_is_div(op_r)) begin
            fix_in_s = {{WIDTH{1'b0}}, acc_r[WIDTH-1:0]};
        end else begin
            fix_in_s = acc_r;
        end
    end

    md_negate #(.P(2*WIDTH)) u_fix (.neg(sign_r), .a(fix_in_s), .y(fix_out_s));

    assign result_fix_s = md_op_is_high(op_r) ? fix_out_s[2*WIDTH-1:WIDTH] : fix_out_s[WIDTH-1:0];

    // Control FSM, iteration registers and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= MD_IDLE;
            op_r        <= 3'd0;
            sign_r      <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
            opb_r       <= {WIDTH{1'b0}};
            acc_r       <= {(2*WIDTH){1'b0}};
            rem_r       <= {WIDTH{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            result_r    <= {WIDTH{1'b0}};
        end else if (flush) begin
            state_r     <= MD_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                MD_IDLE: begin
                    if (accept_s) begin
                        op_r       <= op;
                        cnt_r      <= CNT_W'(WIDTH);
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        if (op == MD_OP_RSVD) begin
                            // Zero operands make the fix-up stage yield 0.
                            sign_r  <= 1'b0;
                            opb_r   <= {WIDTH{1'b0}};
                            acc_r   <= {(2*WIDTH){1'b0}};
                            rem_r   <= {WIDTH{1'b0}};
                            state_r <= MD_FIX;
                        end else if (div_zero_s) begin
                            // Preload the architectural divide-by-zero answers.
                            sign_r  <= 1'b0;
                            opb_r   <= {WIDTH{1'b0}};
                            acc_r   <= {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
                            rem_r   <= src0;
                            state_r <= MD_FIX;
                        end else begin
                            sign_r  <= md_op_is_mod(op) ? neg0_s : (neg0_s ^ neg1_s);
                            opb_r   <= is_div_s ? mag1_s : mag0_s;
                            acc_r   <= {{WIDTH{1'b0}}, (is_div_s ? mag0_s : mag1_s)};
                            rem_r   <= {WIDTH{1'b0}};
                            state_r <= MD_CALC;
                        end
                    end else begin
                        state_r <= MD_IDLE;
                    end
                end
                MD_CALC: begin
                    cnt_r <= cnt_r - CNT_W'(1);
                    if (md_op_is_div(op_r)) begin
                        acc_r <= {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-2:0], ~div_diff_s[WIDTH]};
                        rem_r <= div_diff_s[WIDTH] ? div_shift_s[WIDTH-1:0] : div_diff_s[WIDTH-1:0];
                    end else begin
                        acc_r <= {mul_sum_s, acc_r[WIDTH-1:1]};
                    end
                    if (cnt_r == CNT_W'(1)) begin
                        state_r <= MD_FIX;
                    end else begin
                        state_r <= MD_CALC;
                    end
                end
                MD_FIX: begin
                    result_r    <= result_fix_s;
                    busy_r      <= 1'b0;
                    out_valid_r <= 1'b1;
                    state_r     <= MD_DONE;
                end
                MD_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= MD_IDLE;
                    end else begin
                        state_r <= MD_DONE;
                    end
                end
                default: begin
                    state_r     <= MD_IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign result    = result_r;

endmodule

// File: tb/tb_exe_muldiv.sv
// Self-checking bench for exe_muldiv: directed table, corner sequences and
// randomized operations against an arithmetic reference model.
module tb_exe_muldiv;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] src0;
    logic [W-1:0] src1;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs [12];

    exe_muldiv dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .src0(src0), .src1(src1),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain signed/unsigned 64-bit arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] sp;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sp = sa * sb;
        up = {32'd0, a} * {32'd0, b};
        case (o)
            3'd0: return sp[31:0];
            3'd1: return sp[63:32];
            3'd2: return up[63:32];
            3'd3: return (b == 32'd0) ? 32'hFFFF_FFFF : 32'(sa / sb);
            3'd4: return (b == 32'd0) ? a : 32'(sa % sb);
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 32'd0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] o, input logic [31:0] b);
        if (o == 3'd7) return 1;
        if ((o >= 3'd3) && (b == 32'd0)) return 1;
        return W + 1;
    endfunction

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!out_valid && n < 200);
    endtask

    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
        op = o; src0 = a; src1 = b;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(lat);
        chk("out_valid_seen", {31'd0, out_valid}, 32'd1);
        res = result;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] res;
        logic [31:0] held;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [2:0]  ro;
        int          lat;
        int          seen;

        vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
        vecs[2]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        vecs[3]  = '{3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33};
        vecs[5]  = '{3'd5, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 33};
        vecs[6]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33};
        vecs[7]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33};
        vecs[8]  = '{3'd3, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1};
        vecs[9]  = '{3'd6, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1};
        vecs[10] = '{3'd7, 32'h0001_2345, 32'h0000_0678, 32'h0000_0000, 1};
        vecs[11] = '{3'd6, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 33};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = 3'd0; src0 = 32'd0; src1 = 32'd0;
        #2;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_result", result, 32'd0);
        #10 rst = 1'b0;
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
            chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
        end

        // Backpressure: result held, no accept until after the handshake
        op = 3'd0; src0 = 32'd6; src1 = 32'd7;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(lat);
        chk("bp_latency", 32'(lat), 32'd33);
        op = 3'd5; src0 = 32'd100; src1 = 32'd7; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_result", result, 32'd42);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_accept_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_accept_busy", {31'd0, busy}, 32'd1);
        wait_valid(lat);
        chk("bp_second_result", result, 32'd14);
        @(posedge clk); #1;

        // Flush on CALC cycle 10 with a competing request
        op = 3'd0; src0 = 32'd3; src1 = 32'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1; in_valid = 1'b1; src0 = 32'd2; src1 = 32'd2;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        chk("flush_busy", {31'd0, busy}, 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("flush_no_out_valid", 32'(seen), 32'd0);
        chk("flush_result_kept", result, 32'd14);

        // Asynchronous reset in the middle of CALC
        op = 3'd3; src0 = 32'd1000; src1 = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_result", result, 32'd0);
        #1 rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("arst_no_out_valid", 32'(seen), 32'd0);
        do_op(3'd3, 32'd1000, 32'hFFFF_FFFD, res, lat);
        chk("arst_next_result", res, 32'hFFFF_FEB3);

        // Randomized operations against the reference model
        for (int i = 0; i < 150; i++) begin
            ro = 3'($urandom_range(7, 0));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(5, 0))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(16, 1));
                3: ra = 32'($urandom_range(100, 0));
                default: ;
            endcase
            do_op(ro, ra, rb, res, lat);
            chk($sformatf("rand%0d_op%0d_result", i, ro), res, ref_model(ro, ra, rb));
            chk($sformatf("rand%0d_op%0d_latency", i, ro), 32'(lat), 32'(ref_lat(ro, rb)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
